mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences one memory or device-register access at a time.
//               It latches the request, then drives the address and write
//               data onto the system bus with the MAR/MDR/MIO strobes. It
//               waits for device ready and returns read data with a
//               one-cycle ack. Every output is registered.
//               Optional macro MEM_TIMEOUT_EN bounds WAIT to TIMEOUT_CYC
//               cycles and reports expiry on err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        mio_en,
  output logic        r_w,
  output logic        gate_mdr_en,
  input  logic        ready,
  input  logic [15:0] mdr_in
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_ACCESS = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_busy;
  logic        r_ack;
  logic [15:0] r_rdata;
  logic [15:0] r_bus_out;
  logic        r_bus_drive;
  logic        r_ld_mar;
  logic        r_ld_mdr;
  logic        r_mio_en;
  logic        r_r_w;
  logic        r_gate;

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] c_TMO_LAST = 4'(TIMEOUT_CYC - 1);
  logic [3:0] r_cnt;
  logic       r_tmo;
  logic       r_err;
`endif

  // FSM: outputs are assigned together with the next state, so each strobe
  // is high during exactly the cycle of the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= 16'h0;
      r_wdata     <= 16'h0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_rdata     <= 16'h0;
      r_bus_out   <= 16'h0;
      r_bus_drive <= 1'b0;
      r_ld_mar    <= 1'b0;
      r_ld_mdr    <= 1'b0;
      r_mio_en    <= 1'b0;
      r_r_w       <= 1'b0;
      r_gate      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt       <= 4'd0;
      r_tmo       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_state     <= S_ADDR;
            r_busy      <= 1'b1;
            r_bus_out   <= req_addr;
            r_bus_drive <= 1'b1;
            r_ld_mar    <= 1'b1;
          end
        end
        S_ADDR: begin
          r_ld_mar <= 1'b0;
          r_ld_mdr <= 1'b1;
          if (r_we) begin
            r_state     <= S_DATA;
            r_bus_out   <= r_wdata;
            r_bus_drive <= 1'b1;
          end else begin
            // Read: the device loads its MDR from memory during ACCESS.
            r_state     <= S_ACCESS;
            r_bus_out   <= 16'h0;
            r_bus_drive <= 1'b0;
            r_mio_en    <= 1'b1;
            r_r_w       <= 1'b0;
          end
        end
        S_DATA: begin
          r_state     <= S_ACCESS;
          r_bus_out   <= 16'h0;
          r_bus_drive <= 1'b0;
          r_ld_mdr    <= 1'b0;
          r_mio_en    <= 1'b1;
          r_r_w       <= 1'b1;
        end
        S_ACCESS: begin
          r_state  <= S_WAIT;
          r_ld_mdr <= 1'b0;
          r_mio_en <= 1'b0;
          r_r_w    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          r_cnt    <= 4'd0;
`endif
        end
        S_WAIT: begin
          if (ready) begin
            r_state <= S_RESP;
            r_gate  <= ~r_we;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_cnt == c_TMO_LAST) begin
            r_state <= S_RESP;
            r_gate  <= ~r_we;
            r_tmo   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
`endif
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_gate  <= 1'b0;
          r_ack   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (!r_we) r_rdata <= r_tmo ? 16'hFFFF : mdr_in;
          r_err <= r_tmo;
          r_tmo <= 1'b0;
`else
          if (!r_we) r_rdata <= mdr_in;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign bus_out     = r_bus_out;
  assign bus_drive   = r_bus_drive;
  assign ld_mar      = r_ld_mar;
  assign ld_mdr      = r_ld_mdr;
  assign mio_en      = r_mio_en;
  assign r_w         = r_r_w;
  assign gate_mdr_en = r_gate;
`ifdef MEM_TIMEOUT_EN
  assign err         = r_err;
`else
  assign err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Scoreboard bench for mem_access_ctrl with a small device
//               model (MAR/MDR, memory, device data register, ready timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        busy, ack, err, bus_drive, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en;
  logic [15:0] rdata, bus_out;
  logic        ready;
  logic [15:0] mdr_in;

  always #5 clk = ~clk;

  mem_access_ctrl #(
`ifdef MEM_TIMEOUT_EN
    .TIMEOUT_CYC(4)
`else
    .TIMEOUT_CYC(15)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .ack(ack), .rdata(rdata), .err(err),
    .bus_out(bus_out), .bus_drive(bus_drive), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .gate_mdr_en(gate_mdr_en), .ready(ready),
    .mdr_in(mdr_in)
  );

  // ---------------- device model ----------------
  logic [15:0] mar, mdr, ddr;
  logic [15:0] mem [0:15];
  logic        pend;
  logic        force_nrdy = 1'b0;

  function automatic bit is_dev(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE04) || (a == 16'hFE06);
  endfunction

  assign mdr_in = gate_mdr_en ? mdr : 16'h0;

  // Device registers react to the strobes; memory answers one cycle later
  // than the device registers do.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= 16'h0; mdr <= 16'h0; ddr <= 16'h0; ready <= 1'b0; pend <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
      mem[0]  <= 16'h1234;
      mem[4]  <= 16'h5678;
      mem[15] <= 16'hA5A5;
    end else begin
      ready <= 1'b0;
      if (ld_mar) mar <= bus_out;
      if (ld_mdr && !mio_en) mdr <= bus_out;
      if (ld_mdr && mio_en && !r_w) mdr <= mem[mar[3:0]];
      if (mio_en && r_w) begin
        if (mar == 16'hFE06) ddr <= mdr;
        else if (!is_dev(mar)) mem[mar[3:0]] <= mdr;
      end
      if (!force_nrdy) begin
        if (mio_en) begin
          if (is_dev(mar)) ready <= 1'b1;
          else pend <= 1'b1;
        end else if (pend) begin
          ready <= 1'b1;
          pend  <= 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    logic [15:0] rd;
    logic        er;
    int          gates;
    bit          order;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   gate_n = 0;
  int   c_mar = -1, c_mdr = -1, c_wr = -1;
  bit   prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle rules plus pop-and-compare on every ack.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_drive && gate_mdr_en) chk("bus_gate_overlap", 64'd1, 64'd0);
      if (gate_mdr_en) gate_n++;
      if (ld_mar) c_mar = cyc;
      if (ld_mdr) c_mdr = cyc;
      if (mio_en && r_w) c_wr = cyc;
      if (ack) begin
        chk("ack_consecutive", 64'(prev_ack), 64'd0);
        if (q.size() == 0) begin
          chk("ack_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_ack_cycle"}, 64'(cyc), 64'(e.cyc));
          chk({e.name, "_rdata"}, 64'(rdata), 64'(e.rd));
          chk({e.name, "_err"}, 64'(err), 64'(e.er));
          chk({e.name, "_gate_cycles"}, 64'(gate_n), 64'(e.gates));
          if (e.order)
            chk({e.name, "_strobe_order"}, 64'((c_mar < c_mdr) && (c_mdr < c_wr)), 64'd1);
        end
        gate_n = 0;
      end
      prev_ack = ack;
    end else begin
      prev_ack = 1'b0;
      gate_n   = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) return;
    end
    chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic put_req(input logic we, input logic [15:0] a, input logic [15:0] d);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
  endtask

  task automatic push(input int lat, input logic [15:0] rd, input logic er,
                      input int gates, input bit order, input string name);
    exp_t e;
    e.cyc = cyc + lat; e.rd = rd; e.er = er; e.gates = gates; e.order = order; e.name = name;
    q.push_back(e);
  endtask

  // Issue one access from IDLE and drop req once it is accepted.
  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input int lat, input logic [15:0] rd, input logic er,
                       input bit order, input string name);
    wait_idle();
    put_req(we, a, d);
    push(lat, rd, er, we ? 0 : 1, order, name);
    @(negedge clk);
    req = 1'b0;
  endtask

  function automatic logic [40:0] outs();
    return {busy, ack, err, bus_drive, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en, bus_out, rdata};
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", 64'(outs()), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 16'h3000, 16'h0000, 6, 16'h1234, 1'b0, 1'b0, "rd3000");
    issue(1'b1, 16'h3002, 16'hBEEF, 7, 16'h1234, 1'b0, 1'b0, "wr3002");
    issue(1'b0, 16'h3002, 16'h0000, 6, 16'hBEEF, 1'b0, 1'b0, "rd3002");
    issue(1'b1, 16'hFE06, 16'h00AA, 6, 16'hBEEF, 1'b0, 1'b1, "wrFE06");
    wait_idle();
    chk("ddr_value", 64'(ddr), 64'h00AA);

    // Back-to-back: req stays high; the second read is accepted in the ack cycle.
    put_req(1'b0, 16'h3000, 16'h0);
    push(6, 16'h1234, 1'b0, 1, 1'b0, "b2b_first");
    begin : b2b
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (ack) seen = 1'b1;
      end
      if (!seen) chk("b2b_first_timeout", 64'd1, 64'd0);
    end
    req_addr = 16'h3004;
    push(6, 16'h5678, 1'b0, 1, 1'b0, "b2b_second");
    @(negedge clk);
    chk("b2b_busy_after_ack", 64'(busy), 64'd1);
    req = 1'b0;

    issue(1'b0, 16'hFFFF, 16'h0000, 6, 16'hA5A5, 1'b0, 1'b0, "rdFFFF");

    // Reset during ACCESS: everything drops at once and the access is dropped.
    issue(1'b0, 16'h3000, 16'h0000, 6, 16'h1234, 1'b0, 1'b0, "rd_abandoned");
    @(negedge clk);
    chk("mid_access_mio_en", 64'(mio_en), 64'd1);
    rst_n = 1'b0;
    q.delete();
    #1 chk("mid_reset_outputs", 64'(outs()), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    issue(1'b0, 16'h3000, 16'h0000, 6, 16'h1234, 1'b0, 1'b0, "rd_after_reset");

`ifdef MEM_TIMEOUT_EN
    wait_idle();
    force_nrdy = 1'b1;
    issue(1'b0, 16'h3004, 16'h0000, 8, 16'hFFFF, 1'b1, 1'b0, "rd_timeout");
    wait_idle();
    force_nrdy = 1'b0;
`endif

    wait_idle();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
